// File: rtl/traffic_intersection_ctrl.sv
// Round-robin intersection controller: GREEN -> YELLOW -> ALL_RED per approach,
// demand-driven skipping, and a flashing-yellow maintenance mode.
module traffic_intersection_ctrl #(
  parameter int NUM_DIR      = 4,
  parameter int TW           = 8,
  parameter int TICK_DIV     = 50_000_000,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TW-1:0]              green_time,
  input  logic [NUM_DIR-1:0]         demand,
  input  logic                       flash_mode,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [TW-1:0]              phase_left,
  output logic                       in_flash
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [TW-1:0] YELLOW_LD  = TW'(YELLOW_TIME);
  localparam logic [TW-1:0] ALL_RED_LD = TW'(ALL_RED_TIME);

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [TW-1:0]      phase_left_q, phase_left_d;
  logic [DW-1:0]      active_dir_q, active_dir_d;
  logic [NUM_DIR-1:0] pending_q, pending_d;
  logic               flash_phase_q, flash_phase_d;

  logic               tick;
  logic [DW:0]        pick;
  logic [TW-1:0]      green_ld;

  // Returns {found, dir}: the first set request after 'last', wrapping to
  // 'last' itself. Scanning farthest-first lets the nearest match win.
  function automatic logic [DW:0] rr_pick(input logic [NUM_DIR-1:0] req,
                                          input logic [DW-1:0]      last);
    logic [DW:0]   res;
    logic [DW-1:0] idx;
    res = '0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      idx = DW'((int'(last) + k) % NUM_DIR);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d  = tick ? '0 : presc_q + 1'b1;
  assign pick     = rr_pick(pending_q, active_dir_q);
  assign green_ld = (green_time == '0) ? TW'(1) : green_time;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    phase_left_d  = phase_left_q;
    active_dir_d  = active_dir_q;
    flash_phase_d = flash_phase_q;
    pending_d     = pending_q | demand;

    if (tick) begin
      if (state_q == ST_FLASH) begin
        if (!flash_mode) begin
          state_d       = ST_ALL_RED;
          phase_left_d  = ALL_RED_LD;
          flash_phase_d = 1'b0;
        end else begin
          flash_phase_d = ~flash_phase_q;
        end
      end else if (phase_left_q > TW'(1)) begin
        phase_left_d = phase_left_q - 1'b1;
      end else begin
        case (state_q)
          ST_GREEN: begin
            state_d      = ST_YELLOW;
            phase_left_d = YELLOW_LD;
          end
          ST_YELLOW: begin
            state_d      = ST_ALL_RED;
            phase_left_d = ALL_RED_LD;
          end
          default: begin
            if (flash_mode) begin
              state_d       = ST_FLASH;
              phase_left_d  = '0;
              flash_phase_d = 1'b1;
            end else if (pick[DW]) begin
              state_d                  = ST_GREEN;
              active_dir_d             = pick[DW-1:0];
              phase_left_d             = green_ld;
              // A request landing on the entry cycle is served by this green.
              pending_d[pick[DW-1:0]]  = 1'b0;
            end else begin
              phase_left_d = ALL_RED_LD;
            end
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ALL_RED;
      presc_q       <= '0;
      phase_left_q  <= ALL_RED_LD;
      active_dir_q  <= DW'(NUM_DIR - 1);
      pending_q     <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      phase_left_q  <= phase_left_d;
      active_dir_q  <= active_dir_d;
      pending_q     <= pending_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  always_comb begin
    red      = '1;
    yellow   = '0;
    green    = '0;
    in_flash = 1'b0;
    case (state_q)
      ST_GREEN: begin
        green[active_dir_q] = 1'b1;
        red[active_dir_q]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow[active_dir_q] = 1'b1;
        red[active_dir_q]    = 1'b0;
      end
      ST_FLASH: begin
        red      = '0;
        yellow   = {NUM_DIR{flash_phase_q}};
        in_flash = 1'b1;
      end
      default: ;
    endcase
  end

  assign active_dir = active_dir_q;
  assign phase_left = phase_left_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus random traffic,
// all checked against a tick-level behavioural model of the intersection.
module tb_traffic_intersection_ctrl;

  localparam int N   = 4;
  localparam int TW  = 8;
  localparam int TD  = 4;
  localparam int YT  = 2;
  localparam int ART = 1;

  localparam int K_RED   = 0;
  localparam int K_GREEN = 1;
  localparam int K_YEL   = 2;
  localparam int K_FLASH = 3;

  logic          clk;
  logic          rst_n;
  logic [TW-1:0] green_time;
  logic [N-1:0]  demand;
  logic          flash_mode;
  logic [N-1:0]  red, yellow, green;
  logic [1:0]    active_dir;
  logic [TW-1:0] phase_left;
  logic          in_flash;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_intersection_ctrl #(
    .NUM_DIR(N), .TW(TW), .TICK_DIV(TD), .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
  ) dut (
    .clk(clk), .rst_n(rst_n), .green_time(green_time), .demand(demand),
    .flash_mode(flash_mode), .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .phase_left(phase_left), .in_flash(in_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: phase kind, ticks left, served approach, latched requests,
  // blink phase and cycles since reset (a tick is every TD-th cycle).
  typedef struct packed {
    int         kind;
    int         left;
    int         dir;
    logic [3:0] pend;
    logic       fph;
    int         cyc;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.kind = K_RED; s.left = ART; s.dir = N - 1; s.pend = '0; s.fph = 1'b0; s.cyc = 0;
    return s;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [3:0] dem, logic fl, logic [7:0] gt);
    mstate_t n;
    bit      tk;
    n      = s;
    tk     = (s.cyc % TD) == TD - 1;
    n.cyc  = s.cyc + 1;
    n.pend = s.pend | dem;
    if (tk) begin
      if (s.kind == K_FLASH) begin
        if (!fl) begin n.kind = K_RED; n.left = ART; n.fph = 1'b0; end
        else n.fph = ~s.fph;
      end else if (s.left > 1) n.left = s.left - 1;
      else if (s.kind == K_GREEN) begin n.kind = K_YEL; n.left = YT; end
      else if (s.kind == K_YEL) begin n.kind = K_RED; n.left = ART; end
      else if (fl) begin n.kind = K_FLASH; n.left = 0; n.fph = 1'b1; end
      else begin
        n.left = ART;
        for (int k = 1; k <= N; k++) begin
          int d;
          d = (s.dir + k) % N;
          if (s.pend[d]) begin
            n.kind = K_GREEN; n.dir = d; n.left = (gt == 0) ? 1 : int'(gt); n.pend[d] = 1'b0;
            break;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [22:0] exp_vec(mstate_t s);
    logic [3:0] r, y, g;
    logic [7:0] pl;
    logic       f;
    r = 4'hF; y = '0; g = '0; f = 1'b0; pl = 8'(s.left);
    case (s.kind)
      K_GREEN: begin g = 4'b0001 << s.dir; r = ~g; end
      K_YEL:   begin y = 4'b0001 << s.dir; r = ~y; end
      K_FLASH: begin r = '0; y = s.fph ? 4'hF : 4'h0; f = 1'b1; pl = '0; end
      default: ;
    endcase
    return {r, y, g, 2'(s.dir), pl, f};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {red, yellow, green, active_dir, phase_left, in_flash};
  endfunction

  function automatic int oh_idx(logic [3:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, demand, flash_mode, green_time);
  end

  // Holds reset for two cycles with the given inputs, releasing on a falling edge.
  task automatic apply_reset(input logic [7:0] gt, input logic [3:0] dem);
    @(negedge clk);
    rst_n = 1'b0; green_time = gt; demand = dem; flash_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_vec() !== {4'hF, 4'h0, 4'h0, 2'd3, 8'd1, 1'b0}) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), {4'hF, 4'h0, 4'h0, 2'd3, 8'd1, 1'b0});
    end
    apply_reset(8'd3, 4'h0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL reset_idle_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      n_cmp++;
      if (red !== 4'hF || phase_left !== 8'd1) begin n_bad++; $display("FAIL reset_idle_rest i=%0d red=%b pl=%0d exp red=1111 pl=1", i, red, phase_left); end
    end
  endtask

  task automatic test_rotation();
    int         starts[$];
    int         dirs[$];
    int         g0 = 0, y0 = 0;
    logic [3:0] pg = '0;
    apply_reset(8'd3, 4'hF);
    for (int i = 1; i <= 105; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL rotation_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (green !== 4'h0 && pg === 4'h0) begin starts.push_back(i); dirs.push_back(oh_idx(green)); end
      pg = green;
      if (i < 28 && green === 4'b0001) g0++;
      if (i < 28 && yellow === 4'b0001) y0++;
    end
    n_cmp++;
    if (g0 != 12) begin n_bad++; $display("FAIL rotation_green_len got=%0d exp=12", g0); end
    n_cmp++;
    if (y0 != 8) begin n_bad++; $display("FAIL rotation_yellow_len got=%0d exp=8", y0); end
    n_cmp++;
    if (starts.size() < 5) begin
      n_bad++; $display("FAIL rotation_count got=%0d exp>=5", starts.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (starts[k] != 4 + 24 * k || dirs[k] != k % N) begin
          n_bad++; $display("FAIL rotation_order k=%0d got start=%0d dir=%0d exp start=%0d dir=%0d",
                            k, starts[k], dirs[k], 4 + 24 * k, k % N);
        end
      end
    end
  endtask

  task automatic test_skip();
    int g2 = 0, other = 0;
    apply_reset(8'd3, 4'h0);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL skip_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (green === 4'b0100) g2++;
      else if (green !== 4'h0) other++;
      if (i == 4) begin
        n_cmp++;
        if (green !== 4'b0100) begin n_bad++; $display("FAIL skip_first_green got=%b exp=0100", green); end
      end
      if (i >= 24) begin
        n_cmp++;
        if (red !== 4'hF || phase_left !== 8'd1) begin n_bad++; $display("FAIL skip_rest i=%0d red=%b pl=%0d exp red=1111 pl=1", i, red, phase_left); end
      end
      demand = (i == 2) ? 4'b0100 : 4'b0000;
    end
    n_cmp++;
    if (g2 != 12 || other != 0) begin n_bad++; $display("FAIL skip_green_len got g2=%0d other=%0d exp 12/0", g2, other); end
  endtask

  task automatic test_zero_green();
    int         len = 0;
    bit         done = 0;
    apply_reset(8'd0, 4'b0001);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL zero_green_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (green === 4'b0001 && !done) len++;
      else if (len > 0) done = 1;
    end
    n_cmp++;
    if (len != 4) begin n_bad++; $display("FAIL zero_green_len got=%0d exp=4", len); end
  endtask

  task automatic test_flash();
    int g1 = 0, first_flash = -1;
    apply_reset(8'd3, 4'hF);
    for (int i = 1; i <= 76; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL flash_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (green === 4'b0010) g1++;
      if (in_flash === 1'b1 && first_flash < 0) first_flash = i;
      if (i == 53 || i == 57 || i == 61) begin
        n_cmp++;
        if (yellow !== ((i == 57) ? 4'h0 : 4'hF) || red !== 4'h0 || green !== 4'h0) begin
          n_bad++; $display("FAIL flash_blink i=%0d got r=%b y=%b g=%b", i, red, yellow, green);
        end
      end
      if (i == 72) begin
        n_cmp++;
        if (green !== 4'b0100 || in_flash !== 1'b0) begin n_bad++; $display("FAIL flash_resume got green=%b fl=%b exp 0100/0", green, in_flash); end
      end
      if (i == 32) flash_mode = 1'b1;
      if (i == 66) flash_mode = 1'b0;
    end
    n_cmp++;
    if (g1 != 12 || first_flash != 52) begin n_bad++; $display("FAIL flash_entry got g1=%0d first=%0d exp 12/52", g1, first_flash); end
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset(8'd3, 4'hF);
      for (int i = 1; i <= 66; i++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL reset_mid_model p=%0d i=%0d got=%h exp=%h", pass, i, dut_vec(), exp_vec(m)); end
        if (pass == 1 && i == 60) demand = 4'h0;
      end
      n_cmp++;
      if (yellow !== 4'b0100) begin n_bad++; $display("FAIL reset_mid_setup got yellow=%b exp=0100", yellow); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({red, yellow, green, in_flash} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
        n_bad++; $display("FAIL reset_mid_async got r=%b y=%b g=%b fl=%b exp 1111/0000/0000/0", red, yellow, green, in_flash);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 1; j <= 30; j++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL reset_mid_after p=%0d j=%0d got=%h exp=%h", pass, j, dut_vec(), exp_vec(m)); end
        if (pass == 0 && (j == 3 || j == 4)) begin
          n_cmp++;
          if (green !== ((j == 4) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL reset_mid_first j=%0d got green=%b", j, green); end
        end
        if (pass == 1) begin
          n_cmp++;
          if (green !== 4'h0) begin n_bad++; $display("FAIL reset_mid_pending j=%0d got green=%b exp=0000", j, green); end
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    int g0 = 0, g1_start = -1;
    apply_reset(8'd3, 4'h0);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL same_cycle_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (green === 4'b0001) g0++;
      if (green === 4'b0010 && g1_start < 0) g1_start = i;
      demand = (i == 1 || i == 3) ? 4'b0001 : (i == 10) ? 4'b0010 : 4'b0000;
    end
    n_cmp++;
    if (g0 != 12 || g1_start != 28) begin n_bad++; $display("FAIL same_cycle_serve got g0=%0d g1_start=%0d exp 12/28", g0, g1_start); end
  endtask

  task automatic test_random();
    apply_reset(8'd3, 4'h0);
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec(m)) begin n_bad++; $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec(m)); end
      if (!in_flash) begin
        n_cmp++;
        if ($countones(green | yellow) > 1 || (red & (green | yellow)) !== 4'h0) begin
          n_bad++; $display("FAIL random_lamps i=%0d r=%b y=%b g=%b", i, red, yellow, green);
        end
      end
      demand = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 19) == 0) green_time = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) flash_mode = ~flash_mode;
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; green_time = 8'd3; demand = '0; flash_mode = 1'b0;
    test_reset();
    test_rotation();
    test_skip();
    test_zero_green();
    test_flash();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Parametrised multi-approach intersection controller and successor to the single-approach light. It serves NUM_DIR approaches in round-robin order with green, yellow and all-red clearance phases. An internal prescaler derives the time base, and latched demand inputs let the controller skip approaches with no traffic. A flash mode (all yellows blinking) is provided for maintenance or failure operation.

Parameters:
NUM_DIR, 4, number of approaches (2..8)
TW, 8, width of phase timers and of green_time
TICK_DIV, 50_000_000, clk cycles per timing tick (>=2)
YELLOW_TIME, 3, yellow duration in ticks (>=1)
ALL_RED_TIME, 1, all-red clearance duration in ticks (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
green_time  in  TW  green duration in ticks; sampled on GREEN entry
demand  in  NUM_DIR  per-approach vehicle/ped request, level or pulse
flash_mode  in  1  request flashing-yellow operation
red  out  NUM_DIR  red lamp per approach
yellow  out  NUM_DIR  yellow lamp per approach
green  out  NUM_DIR  green lamp per approach
active_dir  out  clog2(NUM_DIR)  approach currently served
phase_left  out  TW  ticks remaining in current phase
in_flash  out  1  high while in FLASH

Behaviour:
- Reset (async, rst_n low):
  - state=ALL_RED, phase_left=ALL_RED_TIME, active_dir=NUM_DIR-1 (first served is dir 0), prescaler=0, pending=0, flash_phase=0.
  - Outputs: red=all 1, yellow=0, green=0, in_flash=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle internal pulse when prescaler==TICK_DIV-1, so the first tick after reset release falls on the TICK_DIV-th rising edge.
  - All phase timing advances only on tick.
- Lamps are a Moore decode of registered state/active_dir:
  - GREEN: green[active_dir]=1; all other approaches red.
  - YELLOW: yellow[active_dir]=1; all other approaches red.
  - ALL_RED: red=all 1.
  - FLASH: red=0, green=0, yellow=all flash_phase.
  - Invariant: at most one bit of green|yellow is set outside FLASH; no approach ever has two lamps lit.
- Phase timer:
  - Loaded on phase entry.
  - On each tick, if phase_left>1 it decrements; if phase_left==1 the phase ends.
  - A phase therefore lasts exactly its loaded value in ticks.
  - green_time==0 is treated as 1.
- Demand latch:
  - pending[i] is set on any cycle demand[i]=1.
  - pending[i] is cleared on the cycle dir i enters GREEN; a set on that same cycle is also cleared (it is served).
- Transitions (all on a tick that ends the phase):
  - GREEN -> YELLOW, loads YELLOW_TIME.
  - YELLOW -> ALL_RED, loads ALL_RED_TIME.
  - ALL_RED with flash_mode=1 -> FLASH, flash_phase=1.
  - ALL_RED otherwise:
    - Search from active_dir+1 (mod NUM_DIR) round-robin for the first pending bit, including active_dir last.
    - If found: active_dir=that dir, GREEN, load green_time.
    - If none: remain ALL_RED, reload ALL_RED_TIME (rest in red) and re-evaluate at the next expiry.
- flash_mode asserted mid-GREEN/YELLOW does not cut the phase short; the controller completes GREEN->YELLOW->ALL_RED, then enters FLASH.
- FLASH:
  - flash_phase toggles each tick.
  - When flash_mode=0 on a tick: -> ALL_RED, load ALL_RED_TIME, flash_phase=0; active_dir is retained, so rotation resumes after it.
- phase_left reads 0 in FLASH.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, NUM_DIR=4, YELLOW_TIME=2, ALL_RED_TIME=1, green_time=3.
- Reset release, demand=4'b1111 held:
  - ALL_RED for 4 cycles, then green=0001 for 12 cycles, yellow=0001 for 8, all-red 4, then green=0010.
  - Rotation continues 0,1,2,3,0.
- demand=4'b0100 pulsed for 1 cycle mid-tick, then 0:
  - Dirs 0 and 1 are skipped; green=0100 for 12 cycles, then yellow, then continuous all-red rest with phase_left cycling 1.
- green_time=0, demand=4'b0001: green[0] lasts exactly 4 cycles (1 tick).
- flash_mode=1 asserted during green[1]:
  - Green completes 12 cycles, then yellow and all-red, then in_flash=1 with yellow=1111 and 0000 alternating every 4 cycles.
  - Deassert: all-red 1 tick, then green=0100.
- rst_n low mid-YELLOW on dir 2:
  - Immediately red=1111, yellow=0, green=0, pending=0.
  - On release, the first green after 4 cycles is dir 0.
- demand[0]=1 asserted on the same cycle dir 0 enters GREEN: pending[0] ends 0; dir 0 is not re-served next rotation unless demand recurs.
